// File: rtl/ledshift_multi.sv
// rtl/ledshift_multi.sv - parametrised LED pattern generator (rotate left/right, bounce, bar fill)
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous reset, active high
//   i_start    in   1      start request (level); ignored while running
//   i_stop     in   1      stop request (level); wins over i_start
//   i_mode     in   2      00 ROTL, 01 ROTR, 10 BOUNCE, 11 FILL; latched on start
//   o_led      out  WIDTH  LED drive, registered
//   o_running  out  1      high while the pattern is running
//   o_tick     out  1      one-clk pulse with each LED step
//   o_wrap     out  1      one-clk pulse with the step that begins a new pattern period
module ledshift_multi #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_led,
    output logic             o_running,
    output logic             o_tick,
    output logic             o_wrap
);

    localparam int CNT_W = $clog2(TICK_DIV + 1);

    localparam logic [1:0] M_ROTL   = 2'b00;
    localparam logic [1:0] M_ROTR   = 2'b01;
    localparam logic [1:0] M_BOUNCE = 2'b10;

    localparam logic [WIDTH-1:0] LED_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] LED_MSB = LED_ONE << (WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] presc;
    logic [1:0]       mode_q;
    logic             dir_up;

    logic [WIDTH-1:0] nxt_led;
    logic             nxt_wrap;
    logic             nxt_dir;
    logic             one_hot;
    logic             fill_ok;
    logic             eff_up;

    // Next LED value for the current mode. Any value that the mode cannot
    // legally hold (e.g. after an upset) falls back to the start pattern.
    always_comb begin
        one_hot  = (o_led != '0) && ((o_led & (o_led - LED_ONE)) == '0);
        fill_ok  = (o_led != '0) && ((o_led & (o_led + LED_ONE)) == '0);
        // Bounce direction is forced by the ends so a stale dir flag can
        // never shift the hot bit out of the bank.
        eff_up   = o_led[0] | (~o_led[WIDTH-1] & dir_up);
        nxt_led  = LED_ONE;
        nxt_wrap = 1'b0;
        nxt_dir  = 1'b1;
        case (mode_q)
            M_ROTL: begin
                if (one_hot) begin
                    nxt_led  = {o_led[WIDTH-2:0], o_led[WIDTH-1]};
                    nxt_wrap = o_led[WIDTH-1];
                end
            end
            M_ROTR: begin
                if (one_hot) begin
                    nxt_led  = {o_led[0], o_led[WIDTH-1:1]};
                    nxt_wrap = o_led[0];
                end else begin
                    nxt_led  = LED_MSB;
                end
            end
            M_BOUNCE: begin
                if (one_hot) begin
                    nxt_led  = eff_up ? (o_led << 1) : (o_led >> 1);
                    nxt_dir  = eff_up;
                    nxt_wrap = ~eff_up & o_led[1];
                end
            end
            default: begin
                if (fill_ok) begin
                    if (&o_led) begin
                        nxt_wrap = 1'b1;
                    end else begin
                        nxt_led = {o_led[WIDTH-2:0], 1'b1};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            presc     <= '0;
            mode_q    <= 2'b00;
            dir_up    <= 1'b1;
            o_led     <= '0;
            o_running <= 1'b0;
            o_tick    <= 1'b0;
            o_wrap    <= 1'b0;
        end else begin
            o_tick <= 1'b0;
            o_wrap <= 1'b0;
            case (state)
                S_IDLE: begin
                    presc     <= '0;
                    o_led     <= '0;
                    o_running <= 1'b0;
                    if (i_start && !i_stop) begin
                        state     <= S_RUN;
                        mode_q    <= i_mode;
                        dir_up    <= 1'b1;
                        o_running <= 1'b1;
                        o_led     <= (i_mode == M_ROTR) ? LED_MSB : LED_ONE;
                    end
                end
                default: begin
                    if (i_stop) begin
                        // A step falling due on this edge is dropped.
                        state     <= S_IDLE;
                        presc     <= '0;
                        o_led     <= '0;
                        o_running <= 1'b0;
                    end else if (presc == CNT_TOP) begin
                        presc  <= '0;
                        o_led  <= nxt_led;
                        dir_up <= nxt_dir;
                        o_tick <= 1'b1;
                        o_wrap <= nxt_wrap;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
